// File: rtl/adder64_sched_pkg.sv
// Shared constants for the adder64 scheduler slice.
// Data width of the shared adder datapath and its pipeline depth.
// Other shared-unit schedulers import this package too.
package adder64_sched_pkg;

  // Operand and sum width of the shared adder.
  localparam int LEN_DATA  = 64;

  // adder64 latency in enabled clock edges from operand capture to sum.
  localparam int ADD64_LAT = 10;

endpackage

// File: rtl/adder64_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           gnt_v,
  output logic [IDW-1:0] gnt_id
);

  // Scan offsets from farthest to nearest so the request closest to ptr wins last.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_v  = 1'b1;
        gnt_id = IDW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/adder64_sched.sv
// Shares one pipelined adder64 among NREQ requesters with round-robin issue.
// Latency: LAT enabled edges from request accept to rsp_valid.
// Backpressure: a head result not accepted freezes the adder, tags and issue.
module adder64_sched
  import adder64_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = ADD64_LAT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*LEN_DATA-1:0]      req_a,
  input  logic [NREQ*LEN_DATA-1:0]      req_b,
  output logic [NREQ-1:0]               rsp_valid,
  input  logic [NREQ-1:0]               rsp_ready,
  output logic [LEN_DATA-1:0]           rsp_sum,
  output logic                          add_en,
  output logic [LEN_DATA-1:0]           add_a,
  output logic [LEN_DATA-1:0]           add_b,
  input  logic [LEN_DATA-1:0]           add_sum,
  output logic [$clog2(LAT+1)-1:0]      inflight,
  output logic                          busy
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  // Tag pipeline mirrors the adder stages: valid bit plus issuing requester.
  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [IDW-1:0] tag_id_q [LAT];
  logic [IDW-1:0] tag_id_d [LAT];
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  inflight_q, inflight_d;

  logic           gnt_v;
  logic [IDW-1:0] gnt_id;
  logic           head_v;
  logic [IDW-1:0] head_id;
  logic           accept;
  logic           retire;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt_v  (gnt_v),
    .gnt_id (gnt_id)
  );

  assign head_v  = tag_v_q[LAT-1];
  assign head_id = tag_id_q[LAT-1];

  // Only an unaccepted head result stalls; everything else keeps flowing.
  assign add_en  = !(head_v && !rsp_ready[head_id]);
  assign retire  = head_v && rsp_ready[head_id];
  assign accept  = gnt_v && add_en;

  assign rsp_sum  = add_sum;
  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0);

  // Decode head tag into a one-hot response valid.
  always_comb begin
    rsp_valid = '0;
    if (head_v) rsp_valid[head_id] = 1'b1;
  end

  // Grant is only offered as ready when the adder is advancing this edge.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  // Steer the granted requester's operands; zeros form a bubble otherwise.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (gnt_v) begin
      add_a = req_a[gnt_id*LEN_DATA +: LEN_DATA];
      add_b = req_b[gnt_id*LEN_DATA +: LEN_DATA];
    end
  end

  // Next tag contents: new grant enters at stage 0, others shift one stage.
  always_comb begin
    tag_v_d     = {tag_v_q[LAT-2:0], gnt_v};
    tag_id_d[0] = gnt_id;
    for (int k = 1; k < LAT; k++) tag_id_d[k] = tag_id_q[k-1];
  end

  // Pointer moves past the requester that was actually accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
  end

  // Issue adds one, retire removes one; both together leave the count alone.
  always_comb begin
    inflight_d = inflight_q;
    case ({accept, retire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Tags advance only with the adder so ids stay aligned with their sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v_q <= '0;
      for (int k = 0; k < LAT; k++) tag_id_q[k] <= '0;
    end else if (add_en) begin
      tag_v_q <= tag_v_d;
      for (int k = 0; k < LAT; k++) tag_id_q[k] <= tag_id_d[k];
    end
  end

  // Arbitration pointer and occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_adder64_sched.sv
// Directed bench for adder64_sched with a behavioural LAT-deep adder.
// Expected sums are queued at issue and matched when responses retire.
// Covers reset, round-robin, throughput, stall, issue/retire overlap, mid-run reset.
module tb_adder64_sched;
  import adder64_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = ADD64_LAT;
  localparam int CW   = $clog2(LAT + 1);

  logic                     clk;
  logic                     rst;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*LEN_DATA-1:0] req_a;
  logic [NREQ*LEN_DATA-1:0] req_b;
  logic [NREQ-1:0]          rsp_valid;
  logic [NREQ-1:0]          rsp_ready;
  logic [LEN_DATA-1:0]      rsp_sum;
  logic                     add_en;
  logic [LEN_DATA-1:0]      add_a;
  logic [LEN_DATA-1:0]      add_b;
  logic [LEN_DATA-1:0]      add_sum;
  logic [CW-1:0]            inflight;
  logic                     busy;

  typedef struct {
    int                  id;
    logic [LEN_DATA-1:0] sum;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  adder64_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .inflight  (inflight),
    .busy      (busy)
  );

  // Behavioural adder: LAT enabled stages, sharing the scheduler reset.
  logic [LEN_DATA-1:0] add_pipe [LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) add_pipe[i] <= '0;
    end else if (add_en) begin
      add_pipe[0] <= add_a + add_b;
      for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end
  assign add_sum = add_pipe[LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [63:0] a, input logic [63:0] b);
    req_valid[i] = v;
    req_a[i*LEN_DATA +: LEN_DATA] = a;
    req_b[i*LEN_DATA +: LEN_DATA] = b;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // Scoreboard monitor: sampled mid-cycle, describes the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("inflight_count", 64'(inflight), 64'(sb.size()));
      chk("busy_flag", busy, sb.size() != 0);
      chk("req_ready_onehot0", $onehot0(req_ready), 1'b1);
      chk("rsp_valid_onehot0", $onehot0(rsp_valid), 1'b1);
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 64'(sb.size()), 64'd1);
          end else begin
            mon_e = sb.pop_front();
            chk("rsp_id", 64'(i), 64'(mon_e.id));
            chk("rsp_sum", rsp_sum, mon_e.sum);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: i, sum: req_a[i*LEN_DATA +: LEN_DATA] + req_b[i*LEN_DATA +: LEN_DATA]});
          grant_log.push_back(i);
        end
      end
    end
  end

  initial begin
    int             k;
    int             first;
    int             run;
    int             total;
    int             nboth;
    logic           acc;
    logic           both;
    logic           stalled;
    logic [63:0]    held;
    logic [CW-1:0]  pre;
    logic [CW-1:0]  maxf;
    logic [63:0]    hist;

    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;

    // Reset state.
    #2;
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_inflight", inflight, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_add_en", add_en, 1'b1);
    chk("rst_req_ready", req_ready, 4'b0000);
    tick();
    tick();
    rst = 1'b1;

    // Single issue: 5 + 7 on req0.
    set_req(0, 1'b1, 64'd5, 64'd7);
    #1;
    chk("single_ready", req_ready, 4'b0001);
    tick();
    set_req(0, 1'b0, 64'd0, 64'd0);
    for (int i = 0; i < LAT - 1; i++) begin
      chk("single_wait_valid", rsp_valid, 4'b0000);
      chk("single_wait_inflight", inflight, 1);
      tick();
    end
    chk("single_rsp_valid", rsp_valid, 4'b0001);
    chk("single_rsp_sum", rsp_sum, 64'd12);
    chk("single_rsp_inflight", inflight, 1);
    tick();
    chk("single_after_valid", rsp_valid, 4'b0000);
    chk("single_after_inflight", inflight, 0);

    // Round-robin from a freshly reset pointer.
    #2;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 64'(i), 64'd100);
    repeat (12) tick();
    req_valid = '0;
    chk("rr_count", 64'(grant_log.size()), 64'd12);
    for (int i = 0; i < 12 && i < grant_log.size(); i++)
      chk("rr_order", 64'(grant_log[i]), 64'(i % NREQ));
    drain("rr_drain");

    // Back-to-back on req1: a=k, b=1.
    maxf = '0;
    hist = '0;
    for (int c = 0; c < LAT + 25; c++) begin
      if (c < 20) set_req(1, 1'b1, 64'(c), 64'd1);
      else set_req(1, 1'b0, 64'd0, 64'd0);
      #1;
      if (c < 20) chk("b2b_ready", req_ready, 4'b0010);
      tick();
      hist[c] = rsp_valid[1];
      if (inflight > maxf) maxf = inflight;
    end
    first = -1;
    total = 0;
    run   = 0;
    for (int c = 0; c < 64; c++) begin
      if (hist[c]) begin
        total++;
        if (first < 0) first = c;
      end
    end
    for (int c = (first < 0 ? 0 : first); c < 64 && hist[c]; c++) run++;
    chk("b2b_total", 64'(total), 64'd20);
    chk("b2b_run", 64'(run), 64'd20);
    chk("b2b_max_inflight", maxf, LAT);
    drain("b2b_drain");

    // Stall: req2 streams, its first result is refused for five cycles.
    k = 0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      set_req(2, 1'b1, 64'(k), 64'd3);
      #1;
      if (!stalled && rsp_valid[2]) begin
        stalled = 1'b1;
        held = rsp_sum;
        rsp_ready[2] = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
          chk("stall_add_en", add_en, 1'b0);
          chk("stall_req_ready", req_ready, 4'b0000);
          chk("stall_rsp_sum", rsp_sum, held);
          chk("stall_rsp_valid", rsp_valid, 4'b0100);
          tick();
        end
        rsp_ready[2] = 1'b1;
        #1;
      end
      acc = req_ready[2];
      tick();
      if (acc) k++;
    end
    set_req(2, 1'b0, 64'd0, 64'd0);
    chk("stall_seen", stalled, 1'b1);
    drain("stall_drain");
    chk("stall_no_loss", 64'(sb.size()), 64'd0);

    // Simultaneous issue and retire on req3.
    nboth = 0;
    for (int c = 0; c < 30; c++) begin
      set_req(3, 1'b1, 64'(c), 64'd5);
      #1;
      pre  = inflight;
      both = req_ready[3] && rsp_valid[3];
      tick();
      if (both) begin
        nboth++;
        chk("sim_inflight_hold", inflight, pre);
        chk("sim_inflight_lat", inflight, LAT);
      end
    end
    set_req(3, 1'b0, 64'd0, 64'd0);
    chk("sim_overlap_edges", 64'(nboth), 64'd20);
    drain("sim_drain");

    // Reset with six operations in flight.
    for (int c = 0; c < 6; c++) begin
      set_req(0, 1'b1, 64'(c), 64'(c));
      tick();
    end
    set_req(0, 1'b0, 64'd0, 64'd0);
    chk("mid_pre_inflight", inflight, 6);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 4'b0000);
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_busy", busy, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    for (int c = 0; c < LAT + 5; c++) begin
      tick();
      chk("mid_no_stale", rsp_valid, 4'b0000);
    end
    set_req(0, 1'b1, 64'd9, 64'd1);
    #1;
    chk("mid_fresh_ready", req_ready, 4'b0001);
    tick();
    set_req(0, 1'b0, 64'd0, 64'd0);
    for (int i = 0; i < LAT - 1; i++) begin
      chk("mid_fresh_wait", rsp_valid, 4'b0000);
      tick();
    end
    chk("mid_fresh_valid", rsp_valid, 4'b0001);
    chk("mid_fresh_sum", rsp_sum, 64'd10);
    tick();
    drain("mid_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
